regfile_2r1w: RTL and testbench

- Parametrised register bank; successor to the single enabled `register` cell.
- Holds DEPTH words of WIDTH bits, with one synchronous write port and two read ports.
- Adds byte-lane write masking, optional hardwired-zero entry 0, optional write-to-read bypass, and selectable read latency.
- Sits in the datapath between decode (register numbers) and the ALU operand latches.

---
 rtl/regfile_pkg.sv | 37 +++
 rtl/regfile_2r1w_read_port.sv | 70 +++++++
 rtl/regfile_2r1w.sv | 96 +++++++++
 tb/tb_regfile_2r1w.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the two-read / one-write register bank.
// Holds the default geometry, the register-number constant for the
// hardwired-zero entry and the byte-lane merge helper used by both the
// write path and the read-port bypass.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_AW    = 5;

    // Register number of the optional hardwired-zero entry.
    localparam int ZERO = 0;

    // Widest word the merge helper handles.
    // Callers zero-extend their words to this width and keep only the
    // low WIDTH bits of the result.
    localparam int MAX_WIDTH = 1024;
    localparam int MAX_LANES = MAX_WIDTH / 8;

    // Lane k of the result is newWord's lane k where be[k] is set,
    // otherwise oldWord's lane k.
    function automatic logic [MAX_WIDTH-1:0] merge(
        input logic [MAX_WIDTH-1:0] oldWord,
        input logic [MAX_WIDTH-1:0] newWord,
        input logic [MAX_LANES-1:0] be
    );
        logic [MAX_WIDTH-1:0] result;
        result = oldWord;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (be[k]) begin
                result[8*k +: 8] = newWord[8*k +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_2r1w_read_port.sv
// One read port of the register bank: address mux, optional same-cycle
// write bypass, hardwired-zero forcing and an optional output register.
// The top level instantiates this twice; the two copies share nothing,
// so both ports behave identically whatever they address.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     rn_i,
    input  logic [WIDTH-1:0]  entries_i [DEPTH],
    input  logic              wEn_i,
    input  logic [AW-1:0]     wn_i,
    input  logic [WIDTH-1:0]  wd_i,
    input  logic [WIDTH/8-1:0] wbe_i,
    output logic [WIDTH-1:0]  rd_o
);

    logic [WIDTH-1:0]           storedWord;
    logic [WIDTH-1:0]           bypassWord;
    logic [MAX_WIDTH-WIDTH-1:0] unusedMergeHi;
    logic [WIDTH-1:0]           readVal;
    logic [WIDTH-1:0]           rd_d;
    logic [WIDTH-1:0]           rd_q;
    logic                       zeroHit;
    logic                       writeHit;

    assign storedWord = entries_i[rn_i];

    // The bypass value is exactly what the entry will hold after the edge:
    // enabled lanes from the write data, the rest from storage.
    assign {unusedMergeHi, bypassWord} = merge(MAX_WIDTH'(storedWord),
                                               MAX_WIDTH'(wd_i),
                                               MAX_LANES'(wbe_i));

    assign zeroHit  = (ZERO_REG != 0) && (rn_i == AW'(ZERO));
    assign writeHit = (BYPASS != 0) && wEn_i && (wn_i == rn_i);

    // Select the combinational read value; the zero entry wins over bypass.
    always_comb begin
        readVal = storedWord;
        if (writeHit) begin
            readVal = bypassWord;
        end
        if (zeroHit) begin
            readVal = '0;
        end
    end

    assign rd_d = readVal;

    // Output register, used only for the one-cycle read latency mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_o = (READ_LAT != 0) ? rd_q : readVal;

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register bank with one synchronous byte-masked write port
// and two independent read ports. Sits between decode (register numbers)
// and the ALU operand latches. Geometry rules: WIDTH is a multiple of 8,
// DEPTH is a power of two of at least 2 and AW = log2(DEPTH), so every
// address is in range.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AW-1:0]      rn1,
    input  logic [AW-1:0]      rn2,
    output logic [WIDTH-1:0]   rd1,
    output logic [WIDTH-1:0]   rd2,
    input  logic [AW-1:0]      wn,
    input  logic [WIDTH-1:0]   wd,
    input  logic               w,
    input  logic [WIDTH/8-1:0] wbe
);

    logic [WIDTH-1:0]           entries [DEPTH];
    logic [WIDTH-1:0]           writeWord;
    logic [MAX_WIDTH-WIDTH-1:0] unusedMergeHi;

    // New contents for the addressed entry; with no lane enabled this is
    // just the old contents, so a zero byte mask writes nothing.
    assign {unusedMergeHi, writeWord} = merge(MAX_WIDTH'(entries[wn]),
                                              MAX_WIDTH'(wd),
                                              MAX_LANES'(wbe));

    for (genvar i = 0; i < DEPTH; i++) begin : gEntry
        if ((ZERO_REG != 0) && (i == ZERO)) begin : gZero
            assign entries[i] = '0;
        end else begin : gStore
            logic [WIDTH-1:0] entry_q;

            // Each entry clears asynchronously and takes the merged word
            // when the write port addresses it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= '0;
                end else if (w && (wn == AW'(i))) begin
                    entry_q <= writeWord;
                end
            end

            assign entries[i] = entry_q;
        end
    end

    rf_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .READ_LAT (READ_LAT)
    ) uReadPort1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rn_i      (rn1),
        .entries_i (entries),
        .wEn_i     (w),
        .wn_i      (wn),
        .wd_i      (wd),
        .wbe_i     (wbe),
        .rd_o      (rd1)
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .READ_LAT (READ_LAT)
    ) uReadPort2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rn_i      (rn2),
        .entries_i (entries),
        .wEn_i     (w),
        .wn_i      (wn),
        .wd_i      (wd),
        .wbe_i     (wbe),
        .rd_o      (rd2)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Testbench for regfile_2r1w. Group A is four 32x32 banks in different
// ZERO_REG/BYPASS/READ_LAT configurations sharing one set of inputs for
// directed scenarios. Group B is four 16x16 banks covering every
// BYPASS/READ_LAT combination, driven by a shared random stream and
// compared against an array-based reference model.
module tb_regfile_2r1w;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [4:0]  aRn1, aRn2, aWn;
    logic [31:0] aWd;
    logic        aW;
    logic [3:0]  aWbe;
    logic [31:0] aRd1 [4];
    logic [31:0] aRd2 [4];

    logic [3:0]  bRn1, bRn2, bWn;
    logic [15:0] bWd;
    logic        bW;
    logic [1:0]  bWbe;
    logic [15:0] bRd1 [4];
    logic [15:0] bRd2 [4];

    logic [15:0] model [16];

    int compared   = 0;
    int mismatched = 0;

    // A0: zero reg, bypass, comb read
    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)) dutA0 (
        .clk(clk), .rst_n(rst_n), .rn1(aRn1), .rn2(aRn2), .rd1(aRd1[0]), .rd2(aRd2[0]),
        .wn(aWn), .wd(aWd), .w(aW), .wbe(aWbe));
    // A1: zero reg, no bypass, comb read
    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(0), .READ_LAT(0)) dutA1 (
        .clk(clk), .rst_n(rst_n), .rn1(aRn1), .rn2(aRn2), .rd1(aRd1[1]), .rd2(aRd2[1]),
        .wn(aWn), .wd(aWd), .w(aW), .wbe(aWbe));
    // A2: zero reg, bypass, registered read
    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1), .READ_LAT(1)) dutA2 (
        .clk(clk), .rst_n(rst_n), .rn1(aRn1), .rn2(aRn2), .rd1(aRd1[2]), .rd2(aRd2[2]),
        .wn(aWn), .wd(aWd), .w(aW), .wbe(aWbe));
    // A3: ordinary entry 0, bypass, comb read
    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(0), .BYPASS(1), .READ_LAT(0)) dutA3 (
        .clk(clk), .rst_n(rst_n), .rn1(aRn1), .rn2(aRn2), .rd1(aRd1[3]), .rd2(aRd2[3]),
        .wn(aWn), .wd(aWd), .w(aW), .wbe(aWbe));

    // Index i: BYPASS = i % 2, READ_LAT = i / 2
    regfile_2r1w #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(1), .BYPASS(0), .READ_LAT(0)) dutB0 (
        .clk(clk), .rst_n(rst_n), .rn1(bRn1), .rn2(bRn2), .rd1(bRd1[0]), .rd2(bRd2[0]),
        .wn(bWn), .wd(bWd), .w(bW), .wbe(bWbe));
    regfile_2r1w #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)) dutB1 (
        .clk(clk), .rst_n(rst_n), .rn1(bRn1), .rn2(bRn2), .rd1(bRd1[1]), .rd2(bRd2[1]),
        .wn(bWn), .wd(bWd), .w(bW), .wbe(bWbe));
    regfile_2r1w #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(1), .BYPASS(0), .READ_LAT(1)) dutB2 (
        .clk(clk), .rst_n(rst_n), .rn1(bRn1), .rn2(bRn2), .rd1(bRd1[2]), .rd2(bRd2[2]),
        .wn(bWn), .wd(bWd), .w(bW), .wbe(bWbe));
    regfile_2r1w #(.WIDTH(16), .DEPTH(16), .AW(4), .ZERO_REG(1), .BYPASS(1), .READ_LAT(1)) dutB3 (
        .clk(clk), .rst_n(rst_n), .rn1(bRn1), .rn2(bRn2), .rd1(bRd1[3]), .rd2(bRd2[3]),
        .wn(bWn), .wd(bWd), .w(bW), .wbe(bWbe));

    // Byte-lane merge built from a mask: enabled lanes come from newW.
    function automatic logic [31:0] modelMerge(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) mask = mask | (32'hFF << (8 * k));
        end
        return (oldW & ~mask) | (newW & mask);
    endfunction

    // Value a group-B port should present right now for register rn.
    function automatic logic [15:0] expRead(input logic [3:0] rn, input bit bypass);
        logic [31:0] v;
        if (rn == 4'd0) return 16'h0;
        v = {16'h0, model[rn]};
        if (bypass && bW && (bWn == rn)) v = modelMerge(v, {16'h0, bWd}, {2'b00, bWbe});
        return v[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeA(input logic [4:0] n, input logic [31:0] d, input logic [3:0] be);
        aW = 1'b1; aWn = n; aWd = d; aWbe = be;
        tick();
        aW = 1'b0; aWbe = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        aRn1 = '0; aRn2 = '0; aWn = '0; aWd = '0; aW = 1'b0; aWbe = '0;
        bRn1 = '0; bRn2 = '0; bWn = '0; bWd = '0; bW = 1'b0; bWbe = '0;
        #2;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (aRd1[i] !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_a%0d_rd1 got %h want %h", i, aRd1[i], 32'h0);
            end
            compared++;
            if (bRd2[i] !== 16'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_b%0d_rd2 got %h want %h", i, bRd2[i], 16'h0);
            end
        end
        aW = 1'b1; aWn = 5'd1; aWd = 32'hCAFEF00D; aWbe = 4'hF;
        @(posedge clk);
        #1;
        aW = 1'b0; aWbe = 4'h0;
        #3 rst_n = 1'b1;
        aRn1 = 5'd1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (aRd1[i] !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL write_in_reset_a%0d got %h want %h", i, aRd1[i], 32'h0);
            end
        end
    endtask

    task automatic test_async_reset();
        writeA(5'd5, 32'hDEADBEEF, 4'hF);
        aRn1 = 5'd5;
        #1;
        compared++;
        if (aRd1[0] !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL preload_e5 got %h want %h", aRd1[0], 32'hDEADBEEF);
        end
        tick();
        compared++;
        if (aRd1[2] !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL preload_e5_lat1 got %h want %h", aRd1[2], 32'hDEADBEEF);
        end
        #3 rst_n = 1'b0;
        #1;
        compared++;
        if (aRd1[0] !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_comb got %h want %h", aRd1[0], 32'h0);
        end
        compared++;
        if (aRd1[2] !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_lat1 got %h want %h", aRd1[2], 32'h0);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_byte_mask();
        writeA(5'd3, 32'h11223344, 4'hF);
        writeA(5'd3, 32'hAABBCCDD, 4'b0101);
        aRn1 = 5'd3; aRn2 = 5'd3;
        #1;
        for (int i = 0; i < 4; i += 3) begin
            compared++;
            if (aRd2[i] !== 32'h11BB33DD) begin
                mismatched++;
                $display("[TB] FAIL byte_mask_a%0d got %h want %h", i, aRd2[i], 32'h11BB33DD);
            end
        end
        writeA(5'd3, 32'h55555555, 4'h0);
        compared++;
        if (aRd1[1] !== 32'h11BB33DD) begin
            mismatched++;
            $display("[TB] FAIL zero_wbe_no_write got %h want %h", aRd1[1], 32'h11BB33DD);
        end
    endtask

    task automatic test_zero_reg();
        aW = 1'b1; aWn = 5'd0; aWd = 32'hFFFFFFFF; aWbe = 4'hF;
        aRn1 = 5'd0; aRn2 = 5'd0;
        #1;
        compared++;
        if (aRd1[0] !== 32'h0 || aRd2[0] !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL zero_reg_bypass got %h/%h want %h", aRd1[0], aRd2[0], 32'h0);
        end
        compared++;
        if (aRd1[3] !== 32'hFFFFFFFF) begin
            mismatched++;
            $display("[TB] FAIL nonzero_reg_bypass got %h want %h", aRd1[3], 32'hFFFFFFFF);
        end
        tick();
        aW = 1'b0; aWbe = 4'h0;
        compared++;
        if (aRd1[0] !== 32'h0 || aRd2[2] !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL zero_reg_after got %h/%h want %h", aRd1[0], aRd2[2], 32'h0);
        end
        compared++;
        if (aRd2[3] !== 32'hFFFFFFFF) begin
            mismatched++;
            $display("[TB] FAIL nonzero_reg_after got %h want %h", aRd2[3], 32'hFFFFFFFF);
        end
    endtask

    task automatic test_bypass();
        writeA(5'd7, 32'h00000001, 4'hF);
        aW = 1'b1; aWn = 5'd7; aWd = 32'h12345678; aWbe = 4'b0011;
        aRn1 = 5'd7; aRn2 = 5'd7;
        #1;
        compared++;
        if (aRd1[0] !== 32'h00005678 || aRd2[0] !== 32'h00005678) begin
            mismatched++;
            $display("[TB] FAIL bypass_on got %h/%h want %h", aRd1[0], aRd2[0], 32'h00005678);
        end
        compared++;
        if (aRd1[1] !== 32'h00000001 || aRd2[1] !== 32'h00000001) begin
            mismatched++;
            $display("[TB] FAIL bypass_off_before got %h/%h want %h", aRd1[1], aRd2[1], 32'h00000001);
        end
        tick();
        aW = 1'b0; aWbe = 4'h0;
        compared++;
        if (aRd1[1] !== 32'h00005678 || aRd2[1] !== 32'h00005678) begin
            mismatched++;
            $display("[TB] FAIL bypass_off_after got %h/%h want %h", aRd1[1], aRd2[1], 32'h00005678);
        end
        compared++;
        if (aRd1[2] !== 32'h00005678) begin
            mismatched++;
            $display("[TB] FAIL bypass_lat1 got %h want %h", aRd1[2], 32'h00005678);
        end
    endtask

    task automatic test_read_latency();
        writeA(5'd2, 32'd10, 4'hF);
        writeA(5'd4, 32'd40, 4'hF);
        aRn1 = 5'd2;
        tick();
        compared++;
        if (aRd1[2] !== 32'd10) begin
            mismatched++;
            $display("[TB] FAIL lat1_hold_e2 got %0d want %0d", aRd1[2], 10);
        end
        aRn1 = 5'd4;
        #2;
        compared++;
        if (aRd1[2] !== 32'd10) begin
            mismatched++;
            $display("[TB] FAIL lat1_before_edge got %0d want %0d", aRd1[2], 10);
        end
        compared++;
        if (aRd1[0] !== 32'd40) begin
            mismatched++;
            $display("[TB] FAIL lat0_e4 got %0d want %0d", aRd1[0], 40);
        end
        tick();
        compared++;
        if (aRd1[2] !== 32'd40) begin
            mismatched++;
            $display("[TB] FAIL lat1_after_edge got %0d want %0d", aRd1[2], 40);
        end
    endtask

    task automatic test_random_sweep();
        logic [15:0] prev1 [2];
        logic [15:0] prev2 [2];
        logic [15:0] now1 [2];
        logic [15:0] now2 [2];
        logic [15:0] e1, e2;
        int bp, lat;
        for (int r = 0; r < 16; r++) model[r] = 16'h0;
        for (int b = 0; b < 2; b++) begin
            prev1[b] = 16'h0;
            prev2[b] = 16'h0;
        end
        repeat (200) begin
            bWn  = 4'($urandom_range(0, 15));
            bRn1 = ($urandom_range(0, 3) == 0) ? bWn : 4'($urandom_range(0, 15));
            bRn2 = ($urandom_range(0, 3) == 0) ? bWn : 4'($urandom_range(0, 15));
            bW   = ($urandom_range(0, 3) != 0);
            bWd  = 16'($urandom);
            bWbe = 2'($urandom_range(0, 3));
            #2;
            for (int b = 0; b < 2; b++) begin
                now1[b] = expRead(bRn1, b[0]);
                now2[b] = expRead(bRn2, b[0]);
            end
            for (int i = 0; i < 4; i++) begin
                bp  = i % 2;
                lat = i / 2;
                e1  = (lat != 0) ? prev1[bp] : now1[bp];
                e2  = (lat != 0) ? prev2[bp] : now2[bp];
                compared++;
                if (bRd1[i] !== e1) begin
                    mismatched++;
                    $display("[TB] FAIL sweep_b%0d_rd1 rn=%0d got %h want %h", i, bRn1, bRd1[i], e1);
                end
                compared++;
                if (bRd2[i] !== e2) begin
                    mismatched++;
                    $display("[TB] FAIL sweep_b%0d_rd2 rn=%0d got %h want %h", i, bRn2, bRd2[i], e2);
                end
            end
            for (int b = 0; b < 2; b++) begin
                prev1[b] = now1[b];
                prev2[b] = now2[b];
            end
            @(posedge clk);
            if (bW && (bWn != 4'd0)) begin
                e1 = modelMerge({16'h0, model[bWn]}, {16'h0, bWd}, {2'b00, bWbe}) & 32'hFFFF;
                model[bWn] = e1;
            end
            #1;
        end
        bW = 1'b0;
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_byte_mask();
        test_zero_reg();
        test_bypass();
        test_read_latency();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
